// File: rtl/pix_feeder.sv
// pix_feeder: prefetches upstream pixel words into a small FIFO and replays
// them to a downstream controller as one block per start request. The block
// is a memory-init phase (en_init high, one word per cycle) followed by
// NUM_PERIODS stream periods. Each period has PERIOD slots. The last slot of
// every period is an idle slot that carries zero and pops nothing.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to send one block (honoured only in IDLE)
//   src_data   upstream pixel word, 4 pixels of WORD_WIDETH bits
//   src_valid  src_data is valid
//   src_ready  FIFO accepts a word this cycle
//   en_init    memory-init phase indicator (registered)
//   input_raw  pixel word to the downstream controller (registered)
//   busy       high whenever the sequencer is not IDLE
//   done       one-cycle pulse once the block has been fully sent (registered)
//   underrun   sticky: a word was needed while the FIFO was empty (registered)
module pix_feeder #(
   parameter int WORD_WIDETH = 8,
   parameter int INIT_CYCLES = 73,
   parameter int PERIOD      = 24,
   parameter int NUM_PERIODS = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [WORD_WIDETH*4-1:0] src_data,
   input  logic                     src_valid,
   output logic                     src_ready,
   output logic                     en_init,
   output logic [WORD_WIDETH*4-1:0] input_raw,
   output logic                     busy,
   output logic                     done,
   output logic                     underrun
);

   localparam int PW = WORD_WIDETH * 4;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int IW = $clog2(INIT_CYCLES + 1);
   localparam int SW = $clog2(PERIOD + 1);
   localparam int NW = $clog2(NUM_PERIODS + 1);

   typedef enum logic [2:0] {IDLE, PREFILL, INIT, STREAM, DONE} state_t;

   state_t          state;
   logic [IW-1:0]   init_cnt;
   logic [SW-1:0]   slot;
   logic [NW-1:0]   period;

   logic [PW-1:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   fifo_count;

   logic            push;
   logic            pop_req;
   logic            pop;
   logic            starve;
   logic            fifo_empty;
   logic            last_slot;
   logic            finish;
   logic [SW-1:0]   next_slot;
   logic [PW-1:0]   raw_next;

   assign busy       = (state != IDLE);
   assign src_ready  = (state != IDLE) && (state != DONE) && (fifo_count < CW'(FIFO_DEPTH));
   assign push       = src_valid && src_ready;
   assign fifo_empty = (fifo_count == '0);

   assign last_slot  = (slot == SW'(PERIOD - 1));
   assign finish     = last_slot && (period == NW'(NUM_PERIODS - 1));
   assign next_slot  = last_slot ? '0 : slot + 1'b1;

   // Word demand for the coming edge. The STREAM decision looks at the slot
   // being entered, since input_raw is registered one edge ahead.
   always_comb begin
      pop_req = 1'b0;
      case (state)
         PREFILL: pop_req = (fifo_count == CW'(FIFO_DEPTH));
         INIT:    pop_req = 1'b1;
         STREAM:  pop_req = !finish && (next_slot != SW'(PERIOD - 1));
         default: pop_req = 1'b0;
      endcase
   end

   // A demand against an empty FIFO yields zero and flags underrun; the
   // pointers stay put so the sequence timing is never disturbed.
   assign pop      = pop_req && !fifo_empty;
   assign starve   = pop_req && fifo_empty;
   assign raw_next = pop ? fifo_mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= src_data;
      end
   end

   // Any leftover words are discarded while idling, so a new block never
   // sees data from the previous one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (state == IDLE) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         init_cnt  <= '0;
         slot      <= '0;
         period    <= '0;
         en_init   <= 1'b0;
         input_raw <= '0;
         done      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (starve) underrun <= 1'b1;
         case (state)
            IDLE: begin
               en_init   <= 1'b0;
               input_raw <= '0;
               done      <= 1'b0;
               if (start) begin
                  state    <= PREFILL;
                  underrun <= 1'b0;
               end
            end
            PREFILL: begin
               // The FIFO has just become full: enter INIT and show the head.
               if (fifo_count == CW'(FIFO_DEPTH)) begin
                  state     <= INIT;
                  init_cnt  <= '0;
                  en_init   <= 1'b1;
                  input_raw <= raw_next;
               end
            end
            INIT: begin
               input_raw <= raw_next;
               if (init_cnt == IW'(INIT_CYCLES - 1)) begin
                  // This edge already drives STREAM slot 0.
                  state   <= STREAM;
                  en_init <= 1'b0;
                  slot    <= '0;
                  period  <= '0;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            STREAM: begin
               if (finish) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  input_raw <= '0;
               end else begin
                  slot      <= next_slot;
                  input_raw <= raw_next;
                  if (last_slot) period <= period + 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               input_raw <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pix_feeder.sv
// tb_pix_feeder: randomized and directed stimulus for pix_feeder, compared
// every cycle against a queue-based behavioural model of a block schedule.
module tb_pix_feeder;

   localparam int WW   = 8;
   localparam int PW   = WW * 4;
   localparam int IC   = 73;
   localparam int PER  = 24;
   localparam int NP   = 2;
   localparam int FD   = 8;
   localparam int L    = IC + NP * PER;
   localparam int LOGN = 16384;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [PW-1:0] src_data = '0;
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic          en_init;
   logic [PW-1:0] input_raw;
   logic          busy;
   logic          done;
   logic          underrun;

   pix_feeder #(
      .WORD_WIDETH (WW),
      .INIT_CYCLES (IC),
      .PERIOD      (PER),
      .NUM_PERIODS (NP),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .src_data  (src_data),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .en_init   (en_init),
      .input_raw (input_raw),
      .busy      (busy),
      .done      (done),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chkw(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Phase: 0 idle, 1 prefill, 2 running the block schedule, 3 done pulse.
   // The block schedule is a list of L items; item k is an init word when
   // k < IC, otherwise stream slot (k-IC) % PER, which is idle at PER-1.
   int            m_phase;
   logic [PW-1:0] m_q[$];
   int            m_k;
   logic          m_en;
   logic          m_done;
   logic          m_under;
   logic [PW-1:0] m_raw;
   int            m_popped;

   function automatic bit m_ready();
      return (m_phase == 1 || m_phase == 2) && (m_q.size() < FD);
   endfunction

   function automatic void m_reset();
      m_phase = 0; m_q.delete(); m_k = 0;
      m_en = 1'b0; m_done = 1'b0; m_under = 1'b0; m_raw = '0; m_popped = 0;
   endfunction

   function automatic void m_item(input int k);
      bit demand;
      m_en   = (k < IC);
      demand = (k < IC) || (((k - IC) % PER) != PER - 1);
      if (!demand) m_raw = '0;
      else if (m_q.size() == 0) begin
         m_raw = '0; m_under = 1'b1;
      end else begin
         m_raw = m_q.pop_front(); m_popped++;
      end
   endfunction

   initial begin
      bit            rdy;
      bit            psh;
      logic [PW-1:0] w;
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else begin
            rdy = m_ready();
            psh = src_valid && rdy;
            w   = src_data;
            case (m_phase)
               0: begin
                  m_q.delete(); m_raw = '0; m_en = 1'b0; m_done = 1'b0;
                  if (start) begin m_phase = 1; m_under = 1'b0; m_popped = 0; end
               end
               1: if (m_q.size() == FD) begin m_phase = 2; m_k = 0; m_item(0); end
               2: begin
                  m_k++;
                  if (m_k == L) begin
                     m_phase = 3; m_en = 1'b0; m_raw = '0; m_done = 1'b1;
                  end else m_item(m_k);
               end
               default: begin m_done = 1'b0; m_raw = '0; m_phase = 0; end
            endcase
            if (psh) m_q.push_back(w);
         end
      end
   end

   // ---------------- compare process + output log ----------------
   int            cyc = 0;
   logic          log_en   [LOGN];
   logic          log_done [LOGN];
   logic [PW-1:0] log_raw  [LOGN];

   initial forever begin
      @(negedge clk);
      chk1("en_init",   en_init,   m_en);
      chkw("input_raw", input_raw, m_raw);
      chk1("done",      done,      m_done);
      chk1("underrun",  underrun,  m_under);
      chk1("busy",      busy,      m_phase != 0);
      chk1("src_ready", src_ready, m_ready());
      if (cyc < LOGN) begin
         log_en[cyc] = en_init; log_done[cyc] = done; log_raw[cyc] = input_raw;
      end
      cyc++;
   end

   function automatic logic [PW-1:0] lraw(input int i);
      return (i >= 0 && i < LOGN) ? log_raw[i] : 'x;
   endfunction
   function automatic logic len(input int i);
      return (i >= 0 && i < LOGN) ? log_en[i] : 1'bx;
   endfunction
   function automatic logic ldone(input int i);
      return (i >= 0 && i < LOGN) ? log_done[i] : 1'bx;
   endfunction
   function automatic int first_en(input int from);
      for (int i = from; i < cyc && i < LOGN; i++) if (log_en[i]) return i;
      return -1;
   endfunction
   function automatic int count_sel(input int from, input int what);
      int n = 0;
      for (int i = from; i < cyc && i < LOGN; i++) begin
         if (what == 0 && log_en[i]) n++;
         if (what == 1 && log_done[i]) n++;
         if (what == 2 && log_raw[i] != '0) n++;
      end
      return n;
   endfunction

   // ---------------- stimulus ----------------
   int next_val = 1;
   int vmode    = 0;
   int vlimit   = 32'h3fff_ffff;
   int vprob    = 100;
   bit dmode    = 1'b0;

   task automatic drive_cycle(input logic st);
      @(negedge clk);
      start = st;
      case (vmode)
         0:       src_valid = (next_val < vlimit);
         1:       src_valid = 1'b0;
         default: src_valid = ($urandom_range(0, 99) < vprob);
      endcase
      src_data = dmode ? $urandom() : next_val;
      if (src_valid && src_ready) next_val++;
   endtask

   task automatic run_to_idle(input int budget, input int start_odds);
      int i = 0;
      drive_cycle(1'b0);
      while (busy && i < budget) begin
         drive_cycle(start_odds > 0 && $urandom_range(0, start_odds - 1) == 0);
         i++;
      end
      start = 1'b0;
      chk1("block_finished", busy, 1'b0);
   endtask

   task automatic wait_item(input int k);
      for (int i = 0; i < 400 && !(m_phase == 2 && m_k >= k); i++) drive_cycle(1'b0);
      chk1("reached_item", (m_phase == 2 && m_k >= k), 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_en_init"}, en_init, 1'b0);
      chkw({tag, "_input_raw"}, input_raw, '0);
      chk1({tag, "_done"}, done, 1'b0);
      chk1({tag, "_underrun"}, underrun, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_src_ready"}, src_ready, 1'b0);
   endtask

   initial begin
      int s;
      int f;
      #1 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) drive_cycle(1'b0);
      rst_n = 1'b1;
      repeat (3) drive_cycle(1'b0);

      // Normal block with a stray start pulse during INIT.
      next_val = 1; vmode = 0; dmode = 1'b0;
      s = cyc;
      drive_cycle(1'b1);
      wait_item(30);
      drive_cycle(1'b1);
      run_to_idle(600, 0);
      f = first_en(s);
      chk1("t1_init_seen", f >= 0, 1'b1);
      chkw("t1_first_init_word", lraw(f), 1);
      chkw("t1_last_init_word", lraw(f + 72), 73);
      chk1("t1_en_after_init", len(f + 73), 1'b0);
      chkw("t1_p0_slot0", lraw(f + 73), 74);
      chkw("t1_p0_slot22", lraw(f + 95), 96);
      chkw("t1_p0_slot23", lraw(f + 96), 0);
      chkw("t1_p1_slot0", lraw(f + 97), 97);
      chkw("t1_p1_slot22", lraw(f + 119), 119);
      chkw("t1_p1_slot23", lraw(f + 120), 0);
      chk1("t1_done_cycle", ldone(f + 121), 1'b1);
      chkw("t1_en_cycles", count_sel(s, 0), 73);
      chkw("t1_done_pulses", count_sel(s, 1), 1);
      chkw("t1_words_used", count_sel(s, 2), 119);
      chkw("t1_model_words", m_popped, 119);
      chk1("t1_no_underrun", underrun, 1'b0);

      // Prefill stall after 5 words.
      next_val = 1; vlimit = 6; vmode = 0;
      drive_cycle(1'b1);
      repeat (120) drive_cycle(1'b0);
      chk1("t2_stall_en_init", en_init, 1'b0);
      chk1("t2_stall_busy", busy, 1'b1);
      chk1("t2_stall_ready", src_ready, 1'b1);
      vlimit = 32'h3fff_ffff;
      s = cyc;
      run_to_idle(600, 0);
      f = first_en(s);
      chk1("t2_init_seen", f >= 0, 1'b1);
      chkw("t2_first_init_word", lraw(f), 1);
      chkw("t2_p1_slot22", lraw(f + 119), 119);

      // Underrun: supply stops once slot 1 of period 0 is on the output.
      next_val = 1; vmode = 0;
      s = cyc;
      drive_cycle(1'b1);
      wait_item(IC + 1);
      vmode = 1;
      run_to_idle(600, 0);
      f = first_en(s);
      chk1("t3_underrun_sticky", underrun, 1'b1);
      chk1("t3_done_cycle", ldone(f + 121), 1'b1);
      chkw("t3_done_pulses", count_sel(s, 1), 1);
      chkw("t3_tail_zero", lraw(f + 119), 0);

      // Asynchronous reset between edges clears the sticky flag at once.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      drive_cycle(1'b0);
      drive_cycle(1'b0);
      rst_n = 1'b1;

      // Reset in the middle of INIT.
      next_val = 1; vmode = 0;
      drive_cycle(1'b1);
      wait_item(40);
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_init_reset");
      drive_cycle(1'b0);
      drive_cycle(1'b0);
      rst_n = 1'b1;
      repeat (10) drive_cycle(1'b0);
      chk1("t4_idle_busy", busy, 1'b0);
      chk1("t4_idle_ready", src_ready, 1'b0);
      next_val = 500;
      s = cyc;
      drive_cycle(1'b1);
      run_to_idle(600, 0);
      f = first_en(s);
      chkw("t4_first_word", lraw(f), 500);
      chkw("t4_last_init_word", lraw(f + 72), 572);

      // Randomized blocks: random data, random valid duty, stray starts.
      for (int b = 0; b < 6; b++) begin
         vmode = 2; dmode = 1'b1; vprob = $urandom_range(40, 100);
         repeat ($urandom_range(0, 6)) drive_cycle(1'b0);
         drive_cycle(1'b1);
         run_to_idle(2000, 20);
         repeat (2) drive_cycle(1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: no finish by %0t, passed %0d of %0d", $time, n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
